// File: rtl/wf_7seg_scan_ser.sv
// wf_7seg_scan_ser: scanning driver for serial-shift multi-digit 7-segment
// displays. One slot (digit or colon) is refreshed per scan_enable tick by
// shifting a 16-bit frame {segment byte, digit byte} MSB first, then pulsing
// LOAD.
// Optional feature macro: WF_7SEG_DIM_EN (brightness input and frame-counter
// based dimming by dark frames).
module wf_7seg_scan_ser #(
    parameter int N_DIGITS = 4,
    parameter int CLK_DIV  = 1,
    parameter int COLON_EN = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scan_enable,
    input  logic [4*N_DIGITS-1:0] digits,
    input  logic [N_DIGITS-1:0]   dp_mask,
    input  logic [N_DIGITS-1:0]   blank_mask,
    input  logic [1:0]            colon_mode,
`ifdef WF_7SEG_DIM_EN
    input  logic [3:0]            brightness,
`endif
    output logic                  SCLK,
    output logic                  DOUT,
    output logic                  LOAD,
    output logic                  busy,
    output logic                  overrun
);

    localparam int NS     = N_DIGITS + COLON_EN;
    localparam int SLOT_W = $clog2(NS + 1);
    localparam int DIV_W  = $clog2(2 * CLK_DIV + 1);

    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(NS - 1);
    localparam logic [SLOT_W-1:0] SLOT_COLON = SLOT_W'(N_DIGITS);
    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
    // LATCH runs 2*CLK_DIV+1 cycles: a CLK_DIV+1 cycle settle with SCLK low,
    // then CLK_DIV cycles of LOAD high.
    localparam logic [DIV_W-1:0]  LOAD_ON    = DIV_W'(CLK_DIV + 1);
    localparam logic [DIV_W-1:0]  LATCH_LAST = DIV_W'(2 * CLK_DIV);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LATCH
    } state_t;

    state_t            state_q,   state_d;
    logic [SLOT_W-1:0] slot_q,    slot_d;
    logic [15:0]       shifter_q, shifter_d;
    logic [DIV_W-1:0]  div_q,     div_d;
    logic [3:0]        bit_q,     bit_d;
    logic              sclk_q,    sclk_d;
    logic              dout_q,    dout_d;
    logic              load_q,    load_d;
    logic              busy_q,    busy_d;
    logic              overrun_q, overrun_d;
`ifdef WF_7SEG_DIM_EN
    logic [3:0]        fcnt_q,    fcnt_d;
`endif

    logic [7:0]  seg_byte;
    logic [7:0]  dig_byte;
    logic [15:0] frame;
    logic [DIV_W-1:0] div_inc;

    // Active-low hex font, bit order {dp,g,f,e,d,c,b,a}; dp left dark here.
    function automatic logic [7:0] hex_font(input logic [3:0] v);
        logic [7:0] s;
        case (v)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    // Frame for the current slot, built from the live inputs (snapshot taken on accept).
    always_comb begin
        seg_byte = 8'hFF;
        dig_byte = 8'h00;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (slot_q == SLOT_W'(i)) begin
                seg_byte = hex_font(digits[4*i +: 4]);
                if (dp_mask[i]) begin
                    seg_byte[7] = 1'b0;
                end
                if (blank_mask[i]) begin
                    seg_byte = 8'hFF;
                end
                dig_byte = 8'h01 << i;
            end
        end
        if (COLON_EN != 0 && slot_q == SLOT_COLON) begin
            case (colon_mode)
                2'b00:   seg_byte = 8'hFC;
                2'b01:   seg_byte = 8'hFE;
                2'b10:   seg_byte = 8'hFD;
                default: seg_byte = 8'hFF;
            endcase
            dig_byte = 8'h80;
        end
`ifdef WF_7SEG_DIM_EN
        if (fcnt_q >= brightness) begin
            dig_byte = 8'h00;
        end
`endif
        frame = {seg_byte, dig_byte};
    end

    // Next-state and next-output logic for the IDLE/SHIFT/LATCH sequencer.
    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        shifter_d = shifter_q;
        div_d     = div_q;
        bit_d     = bit_q;
        sclk_d    = sclk_q;
        dout_d    = dout_q;
        load_d    = load_q;
        overrun_d = 1'b0;
`ifdef WF_7SEG_DIM_EN
        fcnt_d    = fcnt_q;
`endif
        div_inc   = div_q + DIV_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (scan_enable) begin
                    shifter_d = frame;
                    dout_d    = frame[15];
                    sclk_d    = 1'b0;
                    bit_d     = 4'd0;
                    div_d     = '0;
                    state_d   = ST_SHIFT;
                    slot_d    = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);
`ifdef WF_7SEG_DIM_EN
                    fcnt_d    = fcnt_q + 4'd1;
`endif
                end
            end
            ST_SHIFT: begin
                overrun_d = scan_enable;
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        // Falling SCLK edge: next bit goes out while SCLK is low.
                        sclk_d = 1'b0;
                        if (bit_q == 4'd15) begin
                            state_d = ST_LATCH;
                        end else begin
                            shifter_d = shifter_q << 1;
                            dout_d    = shifter_d[15];
                            bit_d     = bit_q + 4'd1;
                        end
                    end
                end else begin
                    div_d = div_inc;
                end
            end
            ST_LATCH: begin
                overrun_d = scan_enable;
                if (div_q == LATCH_LAST) begin
                    div_d   = '0;
                    load_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    div_d  = div_inc;
                    load_d = (div_inc >= LOAD_ON);
                end
            end
            default: begin
                state_d = ST_IDLE;
                load_d  = 1'b0;
                sclk_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset aborts any frame in flight without LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            slot_q    <= '0;
            shifter_q <= '0;
            div_q     <= '0;
            bit_q     <= '0;
            sclk_q    <= 1'b0;
            dout_q    <= 1'b0;
            load_q    <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef WF_7SEG_DIM_EN
            fcnt_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            shifter_q <= shifter_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            sclk_q    <= sclk_d;
            dout_q    <= dout_d;
            load_q    <= load_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
`ifdef WF_7SEG_DIM_EN
            fcnt_q    <= fcnt_d;
`endif
        end
    end

    assign SCLK    = sclk_q;
    assign DOUT    = dout_q;
    assign LOAD    = load_q;
    assign busy    = busy_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_wf_7seg_scan_ser.sv
// Testbench for wf_7seg_scan_ser: two instances (default parameters, and
// N_DIGITS=6/CLK_DIV=3/COLON_EN=0), frames reassembled from the serial pins
// and compared with a table-driven reference model.
module tb_wf_7seg_scan_ser;

    localparam int B_ND = 6;
    localparam int B_CD = 3;
`ifdef WF_7SEG_DIM_EN
    localparam bit DIM_ON = 1'b1;
`else
    localparam bit DIM_ON = 1'b0;
`endif

    localparam logic [7:0] FONT [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                         8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a_n, rst_b_n, se_a, se_b;
    logic [27:0] st_digits;
    logic [6:0]  st_dp, st_blank;
    logic [1:0]  st_colon;
    logic [3:0]  st_bright;
    logic        a_sclk, a_dout, a_load, a_busy, a_ovr;
    logic        b_sclk, b_dout, b_load, b_busy, b_ovr;

    wf_7seg_scan_ser dut_a (
        .clk         (clk),
        .rst_n       (rst_a_n),
        .scan_enable (se_a),
        .digits      (st_digits[15:0]),
        .dp_mask     (st_dp[3:0]),
        .blank_mask  (st_blank[3:0]),
        .colon_mode  (st_colon),
`ifdef WF_7SEG_DIM_EN
        .brightness  (st_bright),
`endif
        .SCLK        (a_sclk),
        .DOUT        (a_dout),
        .LOAD        (a_load),
        .busy        (a_busy),
        .overrun     (a_ovr)
    );

    wf_7seg_scan_ser #(.N_DIGITS(B_ND), .CLK_DIV(B_CD), .COLON_EN(0)) dut_b (
        .clk         (clk),
        .rst_n       (rst_b_n),
        .scan_enable (se_b),
        .digits      (st_digits[23:0]),
        .dp_mask     (st_dp[5:0]),
        .blank_mask  (st_blank[5:0]),
        .colon_mode  (st_colon),
`ifdef WF_7SEG_DIM_EN
        .brightness  (st_bright),
`endif
        .SCLK        (b_sclk),
        .DOUT        (b_dout),
        .LOAD        (b_load),
        .busy        (b_busy),
        .overrun     (b_ovr)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Serial-pin monitor for instance A: frame bits, busy/LOAD widths, SCLK phases.
    logic [15:0] a_frame = '0;
    int a_bits = 0, a_blen = 0, a_llen = 0, a_loads = 0, a_viol = 0, a_perr = 0, a_run = 0, a_bits_ld = 0;
    logic a_sclk_p = 1'b0, a_dout_p = 1'b0, a_load_p = 1'b0, a_busy_p = 1'b0;
    always @(negedge clk) begin
        if (a_busy && !a_busy_p) begin
            a_bits = 0; a_frame = '0; a_blen = 0; a_llen = 0; a_run = 1;
        end else if (a_busy) begin
            if (a_sclk != a_sclk_p) begin
                if (a_run != 1) a_perr++;
                a_run = 1;
            end else begin
                a_run++;
            end
        end
        if (a_busy) a_blen++;
        if (a_load) a_llen++;
        if (a_load && !a_load_p) begin a_loads++; a_bits_ld = a_bits; end
        if (a_sclk && !a_sclk_p) begin
            a_frame = {a_frame[14:0], a_dout};
            a_bits++;
            if (a_dout !== a_dout_p) a_viol++;
        end
        if (a_sclk && a_sclk_p && a_dout !== a_dout_p) a_viol++;
        a_sclk_p = a_sclk; a_dout_p = a_dout; a_load_p = a_load; a_busy_p = a_busy;
    end

    // Serial-pin monitor for instance B.
    logic [15:0] b_frame = '0;
    int b_bits = 0, b_blen = 0, b_llen = 0, b_loads = 0, b_viol = 0, b_perr = 0, b_run = 0, b_bits_ld = 0;
    logic b_sclk_p = 1'b0, b_dout_p = 1'b0, b_load_p = 1'b0, b_busy_p = 1'b0;
    always @(negedge clk) begin
        if (b_busy && !b_busy_p) begin
            b_bits = 0; b_frame = '0; b_blen = 0; b_llen = 0; b_run = 1;
        end else if (b_busy) begin
            if (b_sclk != b_sclk_p) begin
                if (b_run != B_CD) b_perr++;
                b_run = 1;
            end else begin
                b_run++;
            end
        end
        if (b_busy) b_blen++;
        if (b_load) b_llen++;
        if (b_load && !b_load_p) begin b_loads++; b_bits_ld = b_bits; end
        if (b_sclk && !b_sclk_p) begin
            b_frame = {b_frame[14:0], b_dout};
            b_bits++;
            if (b_dout !== b_dout_p) b_viol++;
        end
        if (b_sclk && b_sclk_p && b_dout !== b_dout_p) b_viol++;
        b_sclk_p = b_sclk; b_dout_p = b_dout; b_load_p = b_load; b_busy_p = b_busy;
    end

    // Reference model state: slot index and frame counter per instance.
    int ms_slot [2];
    int ms_fcnt [2];

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_frame(input int which);
        int nd, slot;
        logic [7:0] seg, dig;
        logic [3:0] nib;
        nd   = (which == 0) ? 4 : B_ND;
        slot = ms_slot[which];
        if (slot < nd) begin
            nib = st_digits[4*slot +: 4];
            seg = FONT[nib];
            if (st_dp[slot])    seg = seg & 8'h7F;
            if (st_blank[slot]) seg = 8'hFF;
            dig = 8'h01 << slot;
        end else begin
            case (st_colon)
                2'b00:   seg = 8'hFC;
                2'b01:   seg = 8'hFE;
                2'b10:   seg = 8'hFD;
                default: seg = 8'hFF;
            endcase
            dig = 8'h80;
        end
        if (DIM_ON && ms_fcnt[which] >= int'(st_bright)) dig = 8'h00;
        return {seg, dig};
    endfunction

    task automatic start_frame(input int which, output logic [15:0] exp);
        int ns;
        ns  = (which == 0) ? 5 : B_ND;
        exp = model_frame(which);
        ms_slot[which] = (ms_slot[which] + 1) % ns;
        ms_fcnt[which] = (ms_fcnt[which] + 1) % 16;
        @(posedge clk); #1;
        if (which == 0) se_a = 1'b1; else se_b = 1'b1;
        @(posedge clk); #1;
        se_a = 1'b0; se_b = 1'b0;
    endtask

    task automatic finish_frame(input int which, input logic [15:0] exp, input string tag);
        int n;
        logic bz;
        n  = 0;
        bz = (which == 0) ? a_busy : b_busy;
        while (bz && n < 500) begin
            @(negedge clk);
            n++;
            bz = (which == 0) ? a_busy : b_busy;
        end
        chk_val({tag, "_done"}, 32'(bz), 32'd0);
        @(negedge clk); @(negedge clk);
        if (which == 0) begin
            chk_val({tag, "_frame"}, 32'(a_frame), 32'(exp));
            chk_val({tag, "_busy_len"}, a_blen, 32'd35);
            chk_val({tag, "_load_len"}, a_llen, 32'd1);
            chk_val({tag, "_bits_at_load"}, a_bits_ld, 32'd16);
        end else begin
            chk_val({tag, "_frame"}, 32'(b_frame), 32'(exp));
            chk_val({tag, "_busy_len"}, b_blen, 32'(1 + 34 * B_CD));
            chk_val({tag, "_load_len"}, b_llen, 32'(B_CD));
            chk_val({tag, "_bits_at_load"}, b_bits_ld, 32'd16);
        end
    endtask

    task automatic randomize_stim();
        st_digits = 28'($urandom);
        st_dp     = 7'($urandom);
        st_blank  = 7'($urandom_range(0, 3) == 0 ? $urandom : 0);
        st_colon  = 2'($urandom);
        st_bright = 4'($urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] e, e2;
        logic [15:0] dir_exp [6];
        int loads_before, dark;

        dir_exp = '{16'hF901, 16'hA402, 16'hB004, 16'h9908, 16'hFC80, 16'hF901};
        rst_a_n = 1'b0; rst_b_n = 1'b0; se_a = 1'b0; se_b = 1'b0;
        st_digits = '0; st_dp = '0; st_blank = '0; st_colon = 2'b00; st_bright = 4'hF;
        ms_slot[0] = 0; ms_slot[1] = 0; ms_fcnt[0] = 0; ms_fcnt[1] = 0;

        repeat (3) @(posedge clk);
        #1;
        chk_val("reset_outs_a", {27'd0, a_sclk, a_dout, a_load, a_busy, a_ovr}, 32'd0);
        chk_val("reset_outs_b", {27'd0, b_sclk, b_dout, b_load, b_busy, b_ovr}, 32'd0);
        @(negedge clk);
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed rotation through all five slots and back to slot 0.
        st_digits[15:0] = 16'h4321;
        for (int i = 0; i < 6; i++) begin
            start_frame(0, e);
            finish_frame(0, dir_exp[i], $sformatf("dir%0d", i));
        end

        // DP and blanking on slots 1..4.
        st_digits[15:0] = 16'h8888; st_dp = 7'b0000010; st_blank = 7'b0001000;
        start_frame(0, e); finish_frame(0, 16'h0002, "dp_slot1");
        start_frame(0, e); finish_frame(0, e, "dp_slot2");
        start_frame(0, e); finish_frame(0, 16'hFF08, "blank_slot3");
        start_frame(0, e); finish_frame(0, e, "dp_colon");

        // Tick while busy: overrun pulse, frame and rotation unaffected.
        start_frame(0, e);
        repeat (5) @(posedge clk);
        #1 se_a = 1'b1;
        @(posedge clk); #1 se_a = 1'b0;
        chk_val("overrun_pulse", 32'(a_ovr), 32'd1);
        @(posedge clk); #1;
        chk_val("overrun_clear", 32'(a_ovr), 32'd0);
        finish_frame(0, e, "ovr_frame");
        start_frame(0, e2);
        finish_frame(0, e2, "ovr_next");

        // Random frames, inputs changed mid-frame to exercise the snapshot.
        for (int k = 0; k < 30; k++) begin
            randomize_stim();
            start_frame(0, e);
            if (k % 2 == 1) begin
                repeat ($urandom_range(3, 20)) @(posedge clk);
                #1 randomize_stim();
            end
            finish_frame(0, e, $sformatf("rnd%0d", k));
        end

        // Asynchronous reset in the middle of a shift.
        randomize_stim();
        start_frame(0, e);
        repeat (8) @(posedge clk);
        loads_before = a_loads;
        #3 rst_a_n = 1'b0;
        #1;
        chk_val("rst_mid_outs", {27'd0, a_sclk, a_dout, a_load, a_busy, a_ovr}, 32'd0);
        repeat (2) @(negedge clk);
        rst_a_n = 1'b1;
        ms_slot[0] = 0; ms_fcnt[0] = 0;
        repeat (3) @(negedge clk);
        chk_val("rst_mid_no_load", a_loads, loads_before);
        start_frame(0, e);
        finish_frame(0, e, "post_rst");
        chk_val("a_dout_stable", a_viol, 32'd0);
        chk_val("a_sclk_phases", a_perr, 32'd0);

        // Six-digit, no-colon, CLK_DIV=3 instance: 16 consecutive frames.
        dark = 0;
        for (int k = 0; k < 16; k++) begin
            randomize_stim();
            st_bright = 4'd4;
            start_frame(1, e);
            finish_frame(1, e, $sformatf("b%0d", k));
            if (b_frame[7:0] == 8'h00) dark++;
        end
        chk_val("b_dark_frames", dark, DIM_ON ? 32'd12 : 32'd0);
        chk_val("b_dout_stable", b_viol, 32'd0);
        chk_val("b_sclk_phases", b_perr, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
